// File: rtl/psum_store_ctrl.sv
// Partial-sum store sequencer: accumulates num_k passes of num_rows rows into the
// ping-pong psum BRAMs, then streams the finished tile out one row per cycle.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; zero-sized jobs finish with done next cycle
// S_ACC    | issuing rows of the current pass whenever row_avail is high
// S_DRAIN  | last row issued; waiting for its write-back to leave the pipe
// S_SWITCH | one cycle: swap buffer_sel, advance the pass, rewind the row
// S_READ   | reading the final tile, one row per cycle, no stall
// S_RDRAIN | last read data on psum_out; done follows
module psum_store_ctrl #(
    parameter int P_BRAM_ADDR_WIDTH = 5,
    parameter int K_WIDTH           = 8,
    parameter int RD_LAT            = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [P_BRAM_ADDR_WIDTH:0]   num_rows,
    input  logic [K_WIDTH-1:0]           num_k,
    input  logic                         row_avail,
    output logic                         row_issue,
    output logic                         buffer_sel,
    output logic                         first_psum,
    output logic [P_BRAM_ADDR_WIDTH-1:0] psum_prev_addr,
    output logic [P_BRAM_ADDR_WIDTH-1:0] psum_addr,
    output logic                         psum_en,
    output logic                         psum_we,
    output logic                         out_valid,
    output logic [P_BRAM_ADDR_WIDTH-1:0] out_row,
    output logic                         busy,
    output logic                         done
);
    localparam int AW = P_BRAM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_SWITCH,
        S_READ,
        S_RDRAIN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW:0]         r_rows;
    logic [K_WIDTH-1:0]  r_k;
    logic [AW-1:0]       r_row;
    logic [K_WIDTH-1:0]  r_pass;
    logic                r_buf_sel;
    logic [RD_LAT-1:0]   r_vld;
    logic [AW-1:0]       r_prow [RD_LAT];
    logic                r_first0;
    logic                r_out_vld;
    logic [AW-1:0]       r_out_row;
    logic                r_done;

    logic [AW:0]         w_rows_m1;
    logic                w_row_last;
    logic                w_issue;
    logic                w_drained;
    logic                w_done_nxt;

    // Row counter is compared one bit wider so a full-depth tile ends at 2^AW-1 cleanly.
    assign w_rows_m1  = r_rows - 1'b1;
    assign w_row_last = ({1'b0, r_row} == w_rows_m1);
    assign w_issue    = (r_state == S_ACC) && row_avail;
    assign w_drained  = ~|r_vld[RD_LAT-2:0];

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if ((num_rows == '0) || (num_k == '0)) w_done_nxt = 1'b1;
                    else                                   w_state_nxt = S_ACC;
                end
            end
            S_ACC:    if (w_issue && w_row_last) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (w_drained) w_state_nxt = (r_pass < r_k - 1'b1) ? S_SWITCH : S_READ;
            end
            S_SWITCH: w_state_nxt = S_ACC;
            S_READ:   if (w_row_last) w_state_nxt = S_RDRAIN;
            S_RDRAIN: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state   <= S_IDLE;
            r_rows    <= '0;
            r_k       <= '0;
            r_row     <= '0;
            r_pass    <= '0;
            r_buf_sel <= 1'b0;
            r_vld     <= '0;
            r_first0  <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_row <= '0;
            r_done    <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) r_prow[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vld     <= {r_vld[RD_LAT-2:0], w_issue};
            r_prow[0] <= r_row;
            for (int i = 1; i < RD_LAT; i++) r_prow[i] <= r_prow[i-1];
            r_first0  <= w_issue && (r_pass == '0);
            r_out_vld <= (r_state == S_READ);
            r_out_row <= r_row;
            r_done    <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rows <= num_rows;
                        r_k    <= num_k;
                        r_row  <= '0;
                        r_pass <= '0;
                    end
                end
                S_ACC:  if (w_issue) r_row <= w_row_last ? '0 : r_row + 1'b1;
                S_SWITCH: begin
                    r_buf_sel <= ~r_buf_sel;
                    r_pass    <= r_pass + 1'b1;
                    r_row     <= '0;
                end
                S_READ: r_row <= w_row_last ? '0 : r_row + 1'b1;
                default: ;
            endcase
        end
    end

    // During READ the address comes straight from the counter; otherwise from the write-back stage.
    assign row_issue      = w_issue;
    assign buffer_sel     = r_buf_sel;
    assign first_psum     = r_vld[0] & r_first0;
    assign psum_prev_addr = r_row;
    assign psum_addr      = (r_state == S_READ) ? r_row : r_prow[RD_LAT-1];
    assign psum_we        = r_vld[RD_LAT-1];
    assign psum_en        = w_issue | (|r_vld) | (r_state == S_READ);
    assign out_valid      = r_out_vld;
    assign out_row        = r_out_row;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
endmodule

// File: tb/tb_psum_store_ctrl.sv
// Directed bench for psum_store_ctrl: per-cycle trace of each tile run, then
// per-scenario checks of issue/write timing, pass sequencing and readout.
module tb_psum_store_ctrl;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       start = 1'b0;
    logic [5:0] num_rows = '0;
    logic [7:0] num_k = '0;
    logic       row_avail = 1'b0;
    logic       row_issue, buffer_sel, first_psum, psum_en, psum_we, out_valid, busy, done;
    logic [4:0] psum_prev_addr, psum_addr, out_row;

    int errors = 0;
    int checks = 0;
    int ncyc;
    int done_cyc;
    logic exp_bsel = 1'b0;

    logic       lg_issue [0:259];
    logic [4:0] lg_prev  [0:259];
    logic       lg_first [0:259];
    logic       lg_we    [0:259];
    logic [4:0] lg_addr  [0:259];
    logic       lg_bsel  [0:259];
    logic       lg_ov    [0:259];
    logic [4:0] lg_orow  [0:259];
    logic       lg_en    [0:259];

    psum_store_ctrl #(.P_BRAM_ADDR_WIDTH(5), .K_WIDTH(8), .RD_LAT(2)) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows), .num_k(num_k),
        .row_avail(row_avail), .row_issue(row_issue), .buffer_sel(buffer_sel),
        .first_psum(first_psum), .psum_prev_addr(psum_prev_addr), .psum_addr(psum_addr),
        .psum_en(psum_en), .psum_we(psum_we), .out_valid(out_valid), .out_row(out_row),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the first cycle after the start edge. mode 1 = row_avail pattern 1,0,0,1.
    task automatic run_tile(input int rows, input int k, input int mode,
                            input int restart_at, input int abort_at);
        for (int i = 0; i < 260; i++) begin
            lg_issue[i] = 0; lg_prev[i] = 0; lg_first[i] = 0; lg_we[i] = 0; lg_addr[i] = 0;
            lg_bsel[i] = 0; lg_ov[i] = 0; lg_orow[i] = 0; lg_en[i] = 0;
        end
        done_cyc = -1;
        ncyc = 0;
        @(negedge clk);
        num_rows = 6'(rows); num_k = 8'(k); start = 1'b1; row_avail = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 256; n++) begin
            row_avail = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
            if (n == restart_at) begin start = 1'b1; num_rows = 6'd8; end
            else start = 1'b0;
            #1;
            lg_issue[n] = row_issue; lg_prev[n] = psum_prev_addr; lg_first[n] = first_psum;
            lg_we[n] = psum_we; lg_addr[n] = psum_addr; lg_bsel[n] = buffer_sel;
            lg_ov[n] = out_valid; lg_orow[n] = out_row; lg_en[n] = psum_en;
            ncyc = n + 1;
            if (done === 1'b1) begin done_cyc = n; break; end
            if (n == abort_at) begin rstn = 1'b1; break; end
            @(negedge clk);
        end
        start = 1'b0;
        row_avail = 1'b0;
        if (abort_at < 0) begin
            checks++;
            if (done_cyc < 0) begin
                errors++;
                $display("FAIL run_timeout: done not seen within %0d cycles (rows=%0d k=%0d)", ncyc, rows, k);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1; row_avail = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({row_issue, first_psum, psum_en, psum_we, out_valid, busy, done, buffer_sel} !== 8'h00 ||
            psum_addr !== 5'd0 || psum_prev_addr !== 5'd0 || out_row !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got issue=%b we=%b en=%b busy=%b done=%b bsel=%b addr=%0d want all 0",
                     row_issue, psum_we, psum_en, busy, done, buffer_sel, psum_addr);
        end
        rstn = 1'b0; row_avail = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int row = 0, nwe = 0, nout = 0, nfirst = 0;
        run_tile(4, 1, 0, -1, -1);
        for (int n = 0; n < ncyc; n++) begin
            if (lg_issue[n]) begin
                checks++;
                if (lg_prev[n] !== 5'(row) || lg_en[n] !== 1'b1) begin
                    errors++; $display("FAIL single_issue: cyc %0d got prev=%0d en=%b want prev=%0d en=1", n, lg_prev[n], lg_en[n], row);
                end
                checks++;
                if (lg_first[n+1] !== 1'b1) begin
                    errors++; $display("FAIL single_first: cyc %0d got %b want 1", n+1, lg_first[n+1]);
                end
                checks++;
                if (lg_we[n+2] !== 1'b1 || lg_addr[n+2] !== 5'(row)) begin
                    errors++; $display("FAIL single_write: cyc %0d got we=%b addr=%0d want we=1 addr=%0d", n+2, lg_we[n+2], lg_addr[n+2], row);
                end
                row++;
            end
            if (lg_we[n]) nwe++;
            if (lg_first[n]) nfirst++;
            if (lg_ov[n]) begin
                checks++;
                if (lg_orow[n] !== 5'(nout)) begin
                    errors++; $display("FAIL single_out_row: got %0d want %0d", lg_orow[n], nout);
                end
                nout++;
            end
            checks++;
            if (lg_bsel[n] !== exp_bsel) begin
                errors++; $display("FAIL single_bsel: cyc %0d got %b want %b", n, lg_bsel[n], exp_bsel);
            end
        end
        checks++;
        if (row != 4 || nwe != 4 || nfirst != 4 || nout != 4) begin
            errors++; $display("FAIL single_counts: got issues=%0d writes=%0d firsts=%0d outs=%0d want 4 each", row, nwe, nfirst, nout);
        end
        checks++;
        if (done_cyc != 11) begin
            errors++; $display("FAIL single_done_cycle: got %0d want 11", done_cyc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_multi();
        int i = 0, pass, r, nfirst = 0, nout = 0;
        run_tile(4, 3, 0, -1, -1);
        for (int n = 0; n < ncyc; n++) begin
            if (lg_issue[n]) begin
                pass = i / 4; r = i % 4;
                checks++;
                if (lg_prev[n] !== 5'(r) || lg_bsel[n] !== (exp_bsel ^ pass[0])) begin
                    errors++; $display("FAIL multi_issue: issue %0d got prev=%0d bsel=%b want prev=%0d bsel=%b", i, lg_prev[n], lg_bsel[n], r, exp_bsel ^ pass[0]);
                end
                checks++;
                if (lg_first[n+1] !== (pass == 0) || lg_we[n+2] !== 1'b1 || lg_addr[n+2] !== 5'(r)) begin
                    errors++; $display("FAIL multi_pipe: issue %0d got first=%b we=%b addr=%0d want first=%b we=1 addr=%0d", i, lg_first[n+1], lg_we[n+2], lg_addr[n+2], pass == 0, r);
                end
                i++;
            end
            if (lg_first[n]) nfirst++;
            if (lg_ov[n]) begin
                checks++;
                if (lg_orow[n] !== 5'(nout) || lg_bsel[n] !== exp_bsel) begin
                    errors++; $display("FAIL multi_out: got row=%0d bsel=%b want row=%0d bsel=%b", lg_orow[n], lg_bsel[n], nout, exp_bsel);
                end
                nout++;
            end
        end
        checks++;
        if (i != 12 || nfirst != 4 || nout != 4 || done_cyc != 25) begin
            errors++; $display("FAIL multi_counts: got issues=%0d firsts=%0d outs=%0d done_cyc=%0d want 12 4 4 25", i, nfirst, nout, done_cyc);
        end
    endtask

    task automatic test_bubbles();
        int row = 0, nwe = 0, nout = 0;
        logic exp_iss;
        run_tile(4, 1, 1, -1, -1);
        for (int n = 0; n < ncyc; n++) begin
            if (n < 8) begin
                exp_iss = (n % 4 == 0) || (n % 4 == 3);
                checks++;
                if (lg_issue[n] !== exp_iss) begin
                    errors++; $display("FAIL bubble_issue: cyc %0d got %b want %b", n, lg_issue[n], exp_iss);
                end
            end
            if (lg_issue[n]) begin
                checks++;
                if (lg_prev[n] !== 5'(row) || lg_we[n+2] !== 1'b1 || lg_addr[n+2] !== 5'(row)) begin
                    errors++; $display("FAIL bubble_write: cyc %0d got prev=%0d we=%b addr=%0d want %0d 1 %0d", n, lg_prev[n], lg_we[n+2], lg_addr[n+2], row, row);
                end
                row++;
            end
            if (lg_we[n]) nwe++;
            if (lg_ov[n]) begin
                if (lg_orow[n] !== 5'(nout)) begin
                    errors++; $display("FAIL bubble_out_row: got %0d want %0d", lg_orow[n], nout);
                end
                checks++;
                nout++;
            end
        end
        checks++;
        if (row != 4 || nwe != 4 || nout != 4 || done_cyc != 15) begin
            errors++; $display("FAIL bubble_counts: got issues=%0d writes=%0d outs=%0d done_cyc=%0d want 4 4 4 15", row, nwe, nout, done_cyc);
        end
    endtask

    task automatic test_full_depth();
        int i = 0, nout = 0;
        logic [4:0] last_row = '0;
        run_tile(32, 2, 0, -1, -1);
        for (int n = 0; n < ncyc; n++) begin
            if (lg_issue[n]) begin
                checks++;
                if (lg_prev[n] !== 5'(i % 32) || lg_addr[n+2] !== 5'(i % 32) || lg_we[n+2] !== 1'b1) begin
                    errors++; $display("FAIL full_addr: issue %0d got prev=%0d waddr=%0d we=%b want %0d", i, lg_prev[n], lg_addr[n+2], lg_we[n+2], i % 32);
                end
                i++;
            end
            if (lg_ov[n]) begin
                if (lg_orow[n] !== 5'(nout)) begin
                    errors++; $display("FAIL full_out_row: got %0d want %0d", lg_orow[n], nout);
                end
                checks++;
                last_row = lg_orow[n];
                nout++;
            end
        end
        checks++;
        if (i != 64 || nout != 32 || last_row !== 5'd31 || done_cyc != 102) begin
            errors++; $display("FAIL full_counts: got issues=%0d outs=%0d last=%0d done_cyc=%0d want 64 32 31 102", i, nout, last_row, done_cyc);
        end
        exp_bsel = ~exp_bsel;
        checks++;
        if (buffer_sel !== exp_bsel) begin
            errors++; $display("FAIL full_bsel_hold: got %b want %b", buffer_sel, exp_bsel);
        end
    endtask

    task automatic test_noop();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            num_rows = (c == 0) ? 6'd4 : 6'd0;
            num_k    = (c == 0) ? 8'd0 : 8'd2;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || psum_en !== 1'b0 || psum_we !== 1'b0) begin
                errors++; $display("FAIL noop_done: case %0d got done=%b busy=%b en=%b we=%b want 1 0 0 0", c, done, busy, psum_en, psum_we);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || psum_en !== 1'b0 || psum_we !== 1'b0 || buffer_sel !== exp_bsel) begin
                errors++; $display("FAIL noop_after: case %0d got done=%b en=%b we=%b bsel=%b want 0 0 0 %b", c, done, psum_en, psum_we, buffer_sel, exp_bsel);
            end
        end
    endtask

    task automatic test_busy_start();
        int row = 0, nout = 0;
        run_tile(4, 1, 0, 2, -1);
        for (int n = 0; n < ncyc; n++) begin
            if (lg_issue[n]) row++;
            if (lg_ov[n]) nout++;
        end
        checks++;
        if (row != 4 || nout != 4 || done_cyc != 11) begin
            errors++; $display("FAIL busy_start: got issues=%0d outs=%0d done_cyc=%0d want 4 4 11", row, nout, done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        run_tile(4, 2, 0, -1, 3);
        checks++;
        if (lg_issue[3] !== 1'b1 || lg_prev[3] !== 5'd3 || lg_bsel[3] !== exp_bsel) begin
            errors++; $display("FAIL reset_mid_pre: got issue=%b prev=%0d bsel=%b want 1 3 %b", lg_issue[3], lg_prev[3], lg_bsel[3], exp_bsel);
        end
        row_avail = 1'b1;
        @(negedge clk);
        checks++;
        if (psum_we !== 1'b0 || row_issue !== 1'b0 || busy !== 1'b0 || buffer_sel !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got we=%b issue=%b busy=%b bsel=%b want 0 0 0 0", psum_we, row_issue, busy, buffer_sel);
        end
        rstn = 1'b0;
        row_avail = 1'b0;
        exp_bsel = 1'b0;
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_bubbles();
        test_full_depth();
        test_noop();
        test_busy_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psum_store_ctrl.md
Name: psum_store_ctrl

Overview:
- Sequencer for the double-buffered partial-sum store: drives buffer_sel, first_psum, psum_prev_addr, psum_addr, psum_en and psum_we for one output tile.
- Accumulates num_k passes of num_rows psum rows (one COL-wide row per cycle) from the systolic array, ping-ponging the two psum BRAMs each pass, then streams the final tile out row by row.
- Sits between the top-level layer controller (start/done) and the psum store plus array output stage.

Parameters:
- P_BRAM_ADDR_WIDTH, 5, psum buffer address width; max rows per tile = 2^P_BRAM_ADDR_WIDTH.
- K_WIDTH, 8, width of the pass count num_k.
- RD_LAT, 2, cycles from row issue to adder output at the store (1 BRAM read + 1 current_psum register); fixed at 2.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset; synchronous, active-high (asserted = 1), despite the name.
- start  input  1  one-cycle pulse in IDLE; latches num_rows and num_k.
- num_rows  input  P_BRAM_ADDR_WIDTH+1  rows per pass, 1..2^P_BRAM_ADDR_WIDTH.
- num_k  input  K_WIDTH  passes to accumulate, >=1.
- row_avail  input  1  array can present a psum row RD_LAT cycles after a row_issue.
- row_issue  output  1  issue a row now; upstream must drive psum_din valid exactly RD_LAT cycles later.
- buffer_sel  output  1  to store.
- first_psum  output  1  to store.
- psum_prev_addr  output  P_BRAM_ADDR_WIDTH  to store.
- psum_addr  output  P_BRAM_ADDR_WIDTH  to store.
- psum_en  output  1  to store.
- psum_we  output  1  to store.
- out_valid  output  1  psum_out from the store holds final row out_row.
- out_row  output  P_BRAM_ADDR_WIDTH  row index of the current psum_out.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the tile readout completes.

Behaviour:
- Reset (rstn=1 at the clock edge): state IDLE; buffer_sel=0; row counter=0; pass counter=0; all other outputs 0. Reset mid-operation aborts immediately and in-flight writes are dropped; next cycle psum_we=0.
- States: IDLE -> ACC -> DRAIN -> (SWITCH -> ACC | READ) -> RDRAIN -> IDLE.
- IDLE: waits for start. A start while busy is ignored. num_rows=0 or num_k=0 is treated as a no-op: done is pulsed the next cycle.
- ACC (issue stage, cycle t): when row_avail=1, row_issue=1, psum_prev_addr=r, psum_en=1, then r++. row_avail=0 inserts a bubble; nothing is issued.
- Pipeline stage t+1: first_psum=1 iff pass==0 and this slot is valid.
- Pipeline stage t+2: psum_we=1, psum_addr=r. The delay pipeline holds a valid bit, row and first bits.
- psum_en=1 whenever any pipeline stage is valid or an issue occurs.
- Transitions out of ACC: after issuing row num_rows-1, go to DRAIN. DRAIN waits until the pipeline is empty (RD_LAT cycles after the last issue).
- DRAIN exit: if pass < num_k-1, go to SWITCH; otherwise go to READ.
- SWITCH (1 cycle): toggle buffer_sel, pass++, r=0, return to ACC. The new pass reads the buffer just written.
- buffer_sel is constant within a pass. It is not toggled after the last pass, so the final data sits in the buffer that psum_out selects.
- READ: psum_addr=r, psum_en=1, psum_we=0, r++ each cycle, with no stall. out_valid and out_row=r follow 1 cycle later (BRAM latency).
- RDRAIN: after the last out_valid, pulse done, return to IDLE. buffer_sel holds its value.
- Wrap-around: r counts 0..num_rows-1 only; num_rows=2^P_BRAM_ADDR_WIDTH uses the full address range without overflow.
- Pass 0 never depends on stale buffer contents, because first_psum forces a zero addend.

Test Plan:
- Reset during ACC at row 3 -> next cycle psum_we=0, row_issue=0, busy=0, buffer_sel=0; a subsequent start runs cleanly.
- num_rows=4, num_k=1, row_avail=1, psum_din row i = i+1 per lane -> first_psum high at t+1 for all rows; writes go to addr 0..3 at t+2; readout shows out_row 0..3 with values 1..4; done pulses once; buffer_sel stays 0.
- num_rows=4, num_k=3, constant input 5 per lane -> buffer_sel sequence 0,1,0; first_psum only in pass 0; final out rows all =15.
- row_avail toggled 1,0,0,1 during a pass -> row_issue only on 1s; psum_we lands exactly 2 cycles after each issue with the matching psum_addr; no duplicate or missing rows; result unchanged.
- num_rows=32 (full depth), num_k=2 -> addresses 0..31 with no wrap error; out_row ends at 31.
- start with num_k=0 -> done next cycle, no psum_en/psum_we activity; start pulsed while busy -> ignored.
